rhs_cmd_sequencer: RTL and testbench

- Upstream driver of the 32-bit RHS SPI master. It walks a programmable command table and hands each word to the master through the start/done handshake.
- It realigns the RHS two-command-late result pipeline and emits each result tagged with the index of the command that produced it.
- It sits between the host/config register bank and the SPI master, and runs either one pass or continuous loops.

---
 rtl/rhs_seq_pkg.sv | 22 ++
 rtl/rhs_seq_tag_pipe.sv | 38 +++
 rtl/rhs_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_rhs_cmd_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhs_seq_pkg.sv
// Shared types and constants for the RHS command sequencer.
package rhs_seq_pkg;

  localparam int unsigned RHS_WORD_W    = 32;
  localparam logic [31:0] RHS_DUMMY_CMD = 32'hC0FF_0000;
  localparam int unsigned RHS_PIPE_LAT  = 2;
  localparam int unsigned RHS_TAG_IDX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RELEASE,
    FLUSH
  } rhs_seq_state_t;

  typedef struct packed {
    logic                     valid;
    logic [RHS_TAG_IDX_W-1:0] idx;
  } rhs_tag_t;

endpackage

// File: rtl/rhs_seq_tag_pipe.sv
// Tag delay line matching the RHS result latency: the tag pushed at issue
// enters the shift chain on that transaction's done and leaves DEPTH dones later.
module rhs_seq_tag_pipe
  import rhs_seq_pkg::*;
#(
  parameter int unsigned DEPTH = RHS_PIPE_LAT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     push,
  input  rhs_tag_t push_tag,
  input  logic     pop,
  output rhs_tag_t pop_tag
);

  rhs_tag_t pending;
  rhs_tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (clear) begin
      pending <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      if (push) pending <= push_tag;
      if (pop) begin
        stage[0] <= pending;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end
  end

  assign pop_tag = stage[DEPTH-1];

endmodule

// File: rtl/rhs_cmd_sequencer.sv
// Walks the command table into the RHS SPI master and realigns tagged results.
// Optional watchdog: define RHS_SEQ_TIMEOUT_EN.
module rhs_cmd_sequencer
  import rhs_seq_pkg::*;
#(
  parameter int unsigned NUM_CMDS       = 16,
  parameter int unsigned PIPE_LAT       = RHS_PIPE_LAT,
  parameter logic [31:0] DUMMY_CMD      = RHS_DUMMY_CMD,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDX_W         = $clog2(NUM_CMDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [RHS_WORD_W-1:0] cfg_data,
  input  logic [IDX_W:0]        cmd_count,
  input  logic                  run_start,
  input  logic                  run_loop,
  output logic                  seq_busy,
  output logic                  spi_start,
  output logic [RHS_WORD_W-1:0] spi_data_in,
  input  logic                  spi_done,
  input  logic [RHS_WORD_W-1:0] spi_data_out,
  output logic                  res_valid,
  output logic [RHS_WORD_W-1:0] res_data,
  output logic [IDX_W-1:0]      res_idx,
  output logic                  seq_err
);

  localparam int unsigned    FLUSH_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(NUM_CMDS);

  logic [RHS_WORD_W-1:0] cmd_tbl [NUM_CMDS];
  rhs_seq_state_t        state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W:0]        cnt_lat;
  logic                  flushing;
  logic [FLUSH_W-1:0]    flush_cnt;
  logic                  start_ok, addr_ok, more_cmds, flush_last, wd_expired;
  logic                  tag_push, tag_pop, tag_clear;
  rhs_tag_t              push_tag, pop_tag;

  if ((1 << IDX_W) == NUM_CMDS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (32'(cfg_addr) < NUM_CMDS);
  end

  always_ff @(posedge clk) begin
    if (cfg_we && addr_ok) cmd_tbl[cfg_addr] <= cfg_data;
  end

  assign start_ok   = (state == IDLE) && run_start && (cmd_count != '0) && (cmd_count <= CNT_MAX);
  assign more_cmds  = (({1'b0, idx} + (IDX_W+1)'(1)) < cnt_lat);
  assign flush_last = (flush_cnt == FLUSH_W'(PIPE_LAT - 1));
  assign push_tag   = '{valid: !flushing, idx: RHS_TAG_IDX_W'(idx)};
  assign seq_busy   = (state != IDLE);

  rhs_seq_tag_pipe #(.DEPTH(PIPE_LAT)) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .clear    (tag_clear),
    .push     (tag_push),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .pop_tag  (pop_tag)
  );

  if (IDX_W < RHS_TAG_IDX_W) begin : g_tag_hi
    logic unused_tag_hi;
    assign unused_tag_hi = ^pop_tag.idx[RHS_TAG_IDX_W-1:IDX_W];
  end

  always_comb begin
    state_nxt = state;
    tag_push  = 1'b0;
    tag_pop   = 1'b0;
    tag_clear = 1'b0;
    case (state)
      IDLE:      if (start_ok) state_nxt = ISSUE;
      ISSUE: begin
        tag_push  = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (spi_done) begin
        tag_pop   = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE:   if (!spi_done) begin
        if (flushing)                    state_nxt = flush_last ? IDLE : ISSUE;
        else if (more_cmds || run_loop)  state_nxt = ISSUE;
        else                             state_nxt = FLUSH;
      end
      FLUSH:     state_nxt = ISSUE;
      default:   state_nxt = IDLE;
    endcase
    if (wd_expired) begin
      state_nxt = IDLE;
      tag_push  = 1'b0;
      tag_pop   = 1'b0;
      tag_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt_lat     <= '0;
      flushing    <= 1'b0;
      flush_cnt   <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
    end else begin
      state     <= state_nxt;
      res_valid <= 1'b0;
      if (wd_expired) begin
        spi_start <= 1'b0;
        flushing  <= 1'b0;
        flush_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (start_ok) begin
            idx       <= '0;
            cnt_lat   <= cmd_count;
            flushing  <= 1'b0;
            flush_cnt <= '0;
          end
          ISSUE: begin
            spi_start   <= 1'b1;
            spi_data_in <= flushing ? DUMMY_CMD : cmd_tbl[idx];
          end
          WAIT_DONE: if (spi_done) begin
            spi_start <= 1'b0;
            if (pop_tag.valid) begin
              res_valid <= 1'b1;
              res_data  <= spi_data_out;
              res_idx   <= pop_tag.idx[IDX_W-1:0];
            end
          end
          RELEASE: if (!spi_done) begin
            if (flushing) begin
              if (flush_last) flushing <= 1'b0;
              else            flush_cnt <= flush_cnt + FLUSH_W'(1);
            end else if (more_cmds) begin
              idx <= idx + IDX_W'(1);
            end else if (run_loop) begin
              idx <= '0;
            end
          end
          FLUSH: begin
            flushing  <= 1'b1;
            flush_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RHS_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            seq_err_q;

  // One budget covers both the done wait and the done-release wait.
  assign wd_active  = (state == WAIT_DONE) || (state == RELEASE);
  assign wd_expired = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign seq_err    = seq_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      seq_err_q <= 1'b0;
    end else begin
      if (wd_active && !wd_expired) wd_cnt <= wd_cnt + WD_W'(1);
      else                          wd_cnt <= '0;
      if (wd_expired)    seq_err_q <= 1'b1;
      else if (start_ok) seq_err_q <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign wd_expired     = 1'b0;
  assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_rhs_cmd_sequencer.sv
// Randomized bench for rhs_cmd_sequencer with an RHS SPI master model whose
// MISO returns the word sent two transactions earlier.
module tb_rhs_cmd_sequencer;

  localparam int unsigned NCMD  = 16;
  localparam logic [31:0] DUMMY = 32'hC0FF_0000;
  localparam int unsigned TMO   = 50;

  logic        clk, rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [4:0]  cmd_count;
  logic        run_start, run_loop;
  logic        seq_busy, spi_start, spi_done, res_valid, seq_err;
  logic [31:0] spi_data_in, spi_data_out, res_data;
  logic [3:0]  res_idx;

  rhs_cmd_sequencer #(
    .NUM_CMDS       (NCMD),
    .PIPE_LAT       (2),
    .DUMMY_CMD      (DUMMY),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cmd_count    (cmd_count),
    .run_start    (run_start),
    .run_loop     (run_loop),
    .seq_busy     (seq_busy),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_done     (spi_done),
    .spi_data_out (spi_data_out),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_idx      (res_idx),
    .seq_err      (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } res_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] tbl_m [NCMD];
  logic [31:0] exp_mosi [$];
  res_t        exp_res  [$];
  logic [31:0] mosi_q   [$];
  int unsigned txn_cnt   = 0;
  int unsigned dummy_cnt = 0;
  int          stall_txn = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SPI master model
  initial begin
    logic [31:0] word;
    int unsigned this_n, hist, lat, hold;
    bit stall_this, aborted;
    spi_done     = 1'b0;
    spi_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && spi_start) begin
        word       = spi_data_in;
        this_n     = txn_cnt;
        txn_cnt++;
        hist       = mosi_q.size();
        mosi_q.push_back(word);
        stall_this = (int'(this_n) == stall_txn);
        if (word == DUMMY) dummy_cnt++;
        total++;
        assert (exp_mosi.size() != 0) else begin
          bad++;
          $error("FAIL mosi_extra observed=%h expected=no transaction", word);
        end
        if (exp_mosi.size() != 0) chk("mosi_word", word, exp_mosi.pop_front());
        lat     = $urandom_range(3, 0);
        aborted = 1'b0;
        while (!aborted && (lat > 0 || stall_this)) begin
          @(posedge clk); #1;
          if (rst || (stall_this && !spi_start)) aborted = 1'b1;
          else begin
            chk("start_held", 32'(spi_start), 32'd1);
            chk("data_stable", spi_data_in, word);
            if (lat > 0) lat--;
          end
        end
        if (aborted) begin
          mosi_q.delete(mosi_q.size() - 1);
        end else begin
          spi_done     = 1'b1;
          spi_data_out = (hist >= 2) ? mosi_q[hist-2] : (32'hBAD0_0000 | 32'(hist));
          @(posedge clk); #1;
          chk("start_fall", 32'(spi_start), 32'd0);
          hold = $urandom_range(2, 0);
          repeat (hold) begin
            @(posedge clk); #1;
            chk("no_reissue", 32'(spi_start), 32'd0);
          end
          spi_done     = 1'b0;
          spi_data_out = $urandom;
        end
      end
    end
  end

  // Result scoreboard
  initial begin
    res_t e;
    forever begin
      @(posedge clk); #1;
      if (res_valid) begin
        total++;
        assert (exp_res.size() != 0) else begin
          bad++;
          $error("FAIL res_extra observed idx=%0d data=%h expected=no result", res_idx, res_data);
        end
        if (exp_res.size() != 0) begin
          e = exp_res.pop_front();
          chk("res_idx", 32'(res_idx), 32'(e.idx));
          chk("res_data", res_data, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit observed=not finished expected=finished");
    $fatal(1, "time limit reached");
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_entry(input int unsigned a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we   = 1'b1;
    cfg_addr = a[3:0];
    cfg_data = d;
    tbl_m[a] = d;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned k = 0;
    while (seq_busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_reached", 32'(seq_busy), 32'd0);
  endtask

  task automatic run_pass(input int unsigned cnt, input int unsigned passes, input bit poke);
    int unsigned base   = txn_cnt;
    int unsigned base_d = dummy_cnt;
    int unsigned target = cnt * (passes - 1) + 1;
    int unsigned k;
    res_t r;
    for (int unsigned p = 0; p < passes; p++)
      for (int unsigned i = 0; i < cnt; i++) begin
        exp_mosi.push_back(tbl_m[i]);
        r.idx  = i;
        r.data = tbl_m[i];
        exp_res.push_back(r);
      end
    exp_mosi.push_back(DUMMY);
    exp_mosi.push_back(DUMMY);
    @(posedge clk); #1;
    cmd_count = cnt[4:0];
    run_loop  = (passes > 1);
    run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    chk("busy_after_start", 32'(seq_busy), 32'd1);
    if (poke) begin
      cyc(3);
      cmd_count = 5'd1;
      run_start = 1'b1;
      cyc(1);
      run_start = 1'b0;
    end
    if (passes > 1) begin
      k = 0;
      while ((txn_cnt - base) < target && k < 5000) begin
        cyc(1);
        k++;
      end
      chk("loop_last_pass", 32'((txn_cnt - base) >= target), 32'd1);
      run_loop = 1'b0;
    end
    wait_idle(5000);
    cyc(2);
    chk("res_missing", 32'(exp_res.size()), 32'd0);
    chk("mosi_missing", 32'(exp_mosi.size()), 32'd0);
    chk("txn_count", txn_cnt - base, cnt * passes + 2);
    chk("dummy_count", dummy_cnt - base_d, 32'd2);
    chk("seq_err_clear", 32'(seq_err), 32'd0);
  endtask

  initial begin
    int unsigned base, k, n;
    rst       = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    cmd_count = '0;
    run_start = 1'b0;
    run_loop  = 1'b0;
    #1 rst = 1'b1;
    #11;
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_spi_data_in", spi_data_in, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_idx", 32'(res_idx), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_seq_busy", 32'(seq_busy), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Directed three-command pass
    write_entry(0, 32'hA000_0001);
    write_entry(1, 32'hA000_0002);
    write_entry(2, 32'hA000_0003);
    run_pass(3, 1, 1'b0);

    // Continuous loop, three passes of two commands
    write_entry(0, $urandom & 32'h7FFF_FFFF);
    write_entry(1, $urandom & 32'h7FFF_FFFF);
    run_pass(2, 3, 1'b0);

    // Random table, boundary counts, start while busy
    for (int unsigned a = 0; a < NCMD; a++) write_entry(a, $urandom & 32'h7FFF_FFFF);
    run_pass(1, 1, 1'b0);
    run_pass(16, 1, 1'b1);
    run_pass($urandom_range(15, 2), 1, 1'b0);
    run_pass($urandom_range(8, 2), 2, 1'b1);

    // Out-of-range cmd_count is ignored
    base = txn_cnt;
    cmd_count = 5'd0;
    run_start = 1'b1;
    cyc(1);
    run_start = 1'b0;
    cyc(2);
    cmd_count = 5'd17;
    run_start = 1'b1;
    cyc(1);
    run_start = 1'b0;
    cyc(10);
    chk("ignore_busy", 32'(seq_busy), 32'd0);
    chk("ignore_txn", txn_cnt - base, 32'd0);

    // Reset while the third transaction waits for done
    stall_txn = int'(txn_cnt) + 2;
    for (int unsigned i = 0; i < 4; i++) exp_mosi.push_back(tbl_m[i]);
    cmd_count = 5'd4;
    run_start = 1'b1;
    cyc(1);
    run_start = 1'b0;
    k = 0;
    while (int'(txn_cnt) <= stall_txn && k < 1000) begin
      cyc(1);
      k++;
    end
    chk("stall_reached", 32'(int'(txn_cnt) > stall_txn), 32'd1);
    cyc(3);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("arst_spi_start", 32'(spi_start), 32'd0);
    chk("arst_spi_data_in", spi_data_in, 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_data", res_data, 32'd0);
    chk("arst_res_idx", 32'(res_idx), 32'd0);
    chk("arst_seq_busy", 32'(seq_busy), 32'd0);
    exp_mosi.delete();
    exp_res.delete();
    cyc(2);
    @(negedge clk) rst = 1'b0;
    stall_txn = -1;
    run_pass(3, 1, 1'b0);

`ifdef RHS_SEQ_TIMEOUT_EN
    // Watchdog: master never answers
    stall_txn = int'(txn_cnt);
    exp_mosi.push_back(tbl_m[0]);
    cmd_count = 5'd2;
    run_start = 1'b1;
    cyc(1);
    run_start = 1'b0;
    k = 0;
    while (!spi_start && k < 10) begin
      cyc(1);
      k++;
    end
    n = 0;
    while (spi_start && n < 500) begin
      n++;
      cyc(1);
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_seq_err", 32'(seq_err), 32'd1);
    chk("timeout_idle", 32'(seq_busy), 32'd0);
    exp_mosi.delete();
    exp_res.delete();
    stall_txn = -1;
    cyc(2);
    run_pass(2, 1, 1'b0);
`endif

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
